// File: rtl/frame_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// frame_fetch_ctrl
//   Write-side sequencer for the VGA pixel FIFO. Walks a frame buffer with
//   Avalon-MM burst reads and forwards returned words into the FIFO write
//   port. An outstanding-word credit counter plus fifo_almost_full throttle
//   request issue, so data already in flight always has room in the FIFO.
//
// Ports
//   clk, reset_n          : single clock, asynchronous active-low reset
//   enable                : permits issuing new bursts
//   frame_start           : one-cycle pulse, begins a frame (or resyncs)
//   frame_base/words      : frame byte address and length, sampled on start
//   mem_*                 : Avalon-MM burst read master
//   fifo_almost_full/full : pixel FIFO status
//   fifo_wr_valid/data    : FIFO write port (readdata delayed by one cycle)
//   frame_done            : one-cycle pulse once a frame is fully written
//   overflow_err          : sticky, a write was presented to a full FIFO
// ---------------------------------------------------------------------------
module frame_fetch_ctrl #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 32,
  parameter int BYTES_PER_WORD  = 8,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [23:0]       frame_words,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic [7:0]        mem_burstcount,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              fifo_almost_full,
  input  logic              fifo_full,
  output logic              fifo_wr_valid,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              frame_done,
  output logic              overflow_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Wide enough for outstanding plus a maximal burst without wrapping.
  localparam int                CRED_W      = $clog2(MAX_OUTSTANDING + 256) + 1;
  localparam logic [CRED_W-1:0] MAX_OUT_C   = CRED_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] BPW_C       = ADDR_W'(BYTES_PER_WORD);
  localparam logic [23:0]       BURST_LEN_C = 24'(BURST_LEN);
  localparam logic [CRED_W-1:0] CRED_ZERO   = {CRED_W{1'b0}};
  localparam logic [CRED_W-1:0] CRED_ONE    = {{(CRED_W-1){1'b0}}, 1'b1};

  // Next burst length: the remaining words, capped at BURST_LEN.
  function automatic logic [7:0] min_burst(input logic [23:0] left);
    logic [7:0] b;
    if (left < BURST_LEN_C) begin
      b = left[7:0];
    end else begin
      b = BURST_LEN_C[7:0];
    end
    return b;
  endfunction

  logic [1:0]        state_r,      state_s;
  logic [ADDR_W-1:0] addr_r,       addr_s;
  logic [23:0]       words_left_r, words_left_s;
  logic [ADDR_W-1:0] pend_base_r,  pend_base_s;
  logic [23:0]       pend_words_r, pend_words_s;
  logic              discard_r,    discard_s;
  logic              mem_read_r,   mem_read_s;
  logic [7:0]        burst_r,      burst_s;
  logic              done_r,       done_s;
  logic [CRED_W-1:0] outstanding_r, outstanding_s;
  logic              wr_valid_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              ovf_r;

  logic              accept_s;
  logic              resync_s;
  logic [7:0]        next_burst_s;
  logic [CRED_W-1:0] credit_sum_s;
  logic              can_issue_s;
  logic [CRED_W-1:0] out_inc_s;
  logic [CRED_W-1:0] out_dec_s;
  logic [ADDR_W-1:0] addr_step_s;

  assign accept_s     = mem_read_r & ~mem_waitrequest;
  assign resync_s     = frame_start & (state_r != ST_IDLE);
  assign next_burst_s = min_burst(words_left_r);
  assign credit_sum_s = outstanding_r + CRED_W'(next_burst_s);
  assign can_issue_s  = enable & ~fifo_almost_full & (credit_sum_s <= MAX_OUT_C)
                        & (words_left_r != 24'd0);
  assign addr_step_s  = {{(ADDR_W-8){1'b0}}, burst_r} * BPW_C;

  // Credits: add the accepted burst, retire one per returned word. A word can
  // never belong to a burst accepted in the same cycle, so the guard on the
  // decrement only protects against a stray readdatavalid.
  assign out_inc_s     = accept_s ? CRED_W'(burst_r) : CRED_ZERO;
  assign out_dec_s     = (mem_readdatavalid && (outstanding_r != CRED_ZERO)) ? CRED_ONE : CRED_ZERO;
  assign outstanding_s = outstanding_r + out_inc_s - out_dec_s;

  // Next-state logic for the request sequencer.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    words_left_s = words_left_r;
    pend_base_s  = pend_base_r;
    pend_words_s = pend_words_r;
    discard_s    = discard_r;
    mem_read_s   = mem_read_r;
    burst_s      = burst_r;
    done_s       = 1'b0;

    // A pending request always completes its handshake, whatever the state.
    if (accept_s) begin
      mem_read_s   = 1'b0;
      addr_s       = addr_r + addr_step_s;
      words_left_s = words_left_r - {16'd0, burst_r};
    end else begin
      mem_read_s   = mem_read_r;
    end

    // Resync: remember the newest frame; the words still in flight are dropped.
    if (resync_s) begin
      pend_base_s  = frame_base;
      pend_words_s = frame_words;
      discard_s    = 1'b1;
    end else begin
      pend_base_s  = pend_base_r;
      pend_words_s = pend_words_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          if (frame_words != 24'd0) begin
            addr_s       = frame_base;
            words_left_s = frame_words;
            state_s      = ST_REQ;
          end else begin
            done_s       = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (mem_read_r) begin
          if (accept_s && (discard_r || resync_s || (words_left_s == 24'd0))) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_REQ;
          end
        end else if (discard_r || resync_s) begin
          state_s = ST_DRAIN;
        end else if (can_issue_s) begin
          mem_read_s = 1'b1;
          burst_s    = next_burst_s;
        end else begin
          state_s = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (resync_s || (outstanding_r != CRED_ZERO)) begin
          state_s = ST_DRAIN;
        end else if (discard_r) begin
          // Aborted frame fully drained: start the pending frame. A zero-length
          // pending frame behaves like a no-op frame from IDLE.
          discard_s = 1'b0;
          if (pend_words_r != 24'd0) begin
            addr_s       = pend_base_r;
            words_left_s = pend_words_r;
            state_s      = ST_REQ;
          end else begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        mem_read_s = 1'b0;
        discard_s  = 1'b0;
      end
    endcase
  end

  // State, credit and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      words_left_r  <= 24'd0;
      pend_base_r   <= {ADDR_W{1'b0}};
      pend_words_r  <= 24'd0;
      discard_r     <= 1'b0;
      mem_read_r    <= 1'b0;
      burst_r       <= 8'd0;
      done_r        <= 1'b0;
      outstanding_r <= {CRED_W{1'b0}};
      wr_valid_r    <= 1'b0;
      wr_data_r     <= {DATA_W{1'b0}};
      ovf_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      addr_r        <= addr_s;
      words_left_r  <= words_left_s;
      pend_base_r   <= pend_base_s;
      pend_words_r  <= pend_words_s;
      discard_r     <= discard_s;
      mem_read_r    <= mem_read_s;
      burst_r       <= burst_s;
      done_r        <= done_s;
      outstanding_r <= outstanding_s;
      // Words returning in the resync cycle already belong to the aborted frame.
      wr_valid_r    <= mem_readdatavalid & ~(discard_r | resync_s);
      wr_data_r     <= mem_readdata;
      ovf_r         <= ovf_r | (wr_valid_r & fifo_full);
    end
  end

  assign mem_address    = addr_r;
  assign mem_read       = mem_read_r;
  assign mem_burstcount = burst_r;
  assign fifo_wr_valid  = wr_valid_r;
  assign fifo_wr_data   = wr_data_r;
  assign frame_done     = done_r;
  assign overflow_err   = ovf_r;

endmodule
